pc_sequencer: RTL and testbench

Control block for the program counter: decides every cycle whether the PC increments, jumps or freezes.
- Sources jump targets from a host-writable jump lookup table (LUT).
- Keeps a small return-address stack for call/return.
- Runs an IDLE/RUN/HALT state machine that gates execution and reports completion.
- Sits between the instruction decoder and the PC register; drives the PC's reset, absjump_en and target inputs.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/ret_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared definitions for the program-counter sequencer: the execution
//   state enumeration and default sizes for the PC width, the jump LUT
//   index width and the return-address stack depth.
package pc_seq_pkg;

  localparam int D_DEF         = 12;
  localparam int LUT_W_DEF     = 5;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
//   Return-address stack (LIFO) for call/return.
//   Ports:
//     clk, reset   clock, synchronous active-high reset (empties the stack)
//     push         store push_data on top (ignored when full)
//     pop          discard top entry (ignored when empty)
//     push_data    value to push (return address)
//     top          current top entry, 0 when empty
//     full, empty  occupancy status
//   The sequencer never asserts push and pop together; push wins if it does.
module ret_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [D-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  // Index through compares so sp may be wider than the array index.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp == SP_W'(i)) mem[i] <= push_data;
      end
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter control: every cycle decides whether the PC increments,
//   jumps (absolute) or freezes. Jump targets come from a host-writable LUT;
//   call/return use a small return-address stack.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start               leave IDLE and begin execution
//     prog_ctr            current PC value
//     br_en, br_cond      conditional branch strobe and its condition
//     call_en, ret_en     call / return strobes
//     halt_en             halt strobe
//     lut_idx             LUT entry used by branch and call
//     lut_we/waddr/wdata  LUT write port (any state)
//     pc_reset            holds the PC register at 0
//     absjump_en, target  load target into the PC at the next edge
//     done                registered, high while halted
//     ras_ovf, ras_unf    sticky stack overflow / underflow
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | PC held in reset, waiting for start
//   RUN   | decode strobes steer the PC combinationally
//   HALT  | PC frozen via self-jump, done high, exits only on reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D         = D_DEF,
  parameter int LUT_W     = LUT_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [D-1:0]     prog_ctr,
  input  logic             br_en,
  input  logic             br_cond,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             halt_en,
  input  logic [LUT_W-1:0] lut_idx,
  input  logic             lut_we,
  input  logic [LUT_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic             pc_reset,
  output logic             absjump_en,
  output logic [D-1:0]     target,
  output logic             done,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int LUT_N = 2 ** LUT_W;

  state_t         state, state_next;
  logic [D-1:0]   lut [LUT_N];
  logic [D-1:0]   lut_rd;
  logic [D-1:0]   ret_addr;
  logic [D-1:0]   ras_top;
  logic           ras_full, ras_empty;
  logic           push, pop;
  logic           set_ovf, set_unf;

  // Read before write: a same-cycle write to lut_idx is seen next cycle.
  assign lut_rd   = lut[lut_idx];
  // Wraps to 0 at the top of the address space.
  assign ret_addr = prog_ctr + D'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  ret_stack #(
    .D     (D),
    .DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    state_next = state;
    pc_reset   = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    push       = 1'b0;
    pop        = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    case (state)
      IDLE: begin
        pc_reset = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (halt_en) begin
          absjump_en = 1'b1;
          target     = prog_ctr;
          state_next = HALT;
        end else if (ret_en) begin
          if (!ras_empty) begin
            absjump_en = 1'b1;
            target     = ras_top;
            pop        = 1'b1;
          end else begin
            set_unf = 1'b1;
          end
        end else if (call_en) begin
          // The jump is taken even when the return address cannot be saved.
          absjump_en = 1'b1;
          target     = lut_rd;
          if (!ras_full) push = 1'b1;
          else           set_ovf = 1'b1;
        end else if (br_en) begin
          absjump_en = br_cond;
          target     = lut_rd;
        end
      end
      HALT: begin
        absjump_en = 1'b1;
        target     = prog_ctr;
      end
      default: begin
        pc_reset   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == HALT);
      if (set_ovf) ras_ovf <= 1'b1;
      if (set_unf) ras_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] prog_ctr;
  logic        br_en, br_cond, call_en, ret_en, halt_en;
  logic [4:0]  lut_idx;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic        pc_reset, absjump_en, done, ras_ovf, ras_unf;
  logic [11:0] target;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_ctr   (prog_ctr),
    .br_en      (br_en),
    .br_cond    (br_cond),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .halt_en    (halt_en),
    .lut_idx    (lut_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .pc_reset   (pc_reset),
    .absjump_en (absjump_en),
    .target     (target),
    .done       (done),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode number, LUT array, stack as a queue, flags.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode, nxt_mode;
  logic [11:0] m_lut [32];
  logic [11:0] m_stack [$];
  bit          m_ovf, m_unf, m_done;
  bit          e_pc_reset, e_abs;
  logic [11:0] e_tgt;
  bit          do_push, do_pop, do_ovf, do_unf;
  logic [11:0] push_val;

  typedef struct {
    logic [11:0] pc;
    bit          br, cond, call, ret, halt;
    logic [4:0]  idx;
    bit          x_abs;
    logic [11:0] x_tgt;
    bit          x_ovf, x_unf;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_in();
    start = 0; br_en = 0; br_cond = 0; call_en = 0; ret_en = 0; halt_en = 0;
    lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic model_clear();
    m_mode = M_IDLE;
    foreach (m_lut[i]) m_lut[i] = '0;
    m_stack.delete();
    m_ovf = 0; m_unf = 0; m_done = 0;
  endtask

  // Evaluate expected outputs for the current inputs and compare.
  task automatic check_half();
    @(negedge clk);
    e_pc_reset = 0; e_abs = 0; e_tgt = '0; nxt_mode = m_mode;
    do_push = 0; do_pop = 0; do_ovf = 0; do_unf = 0;
    push_val = prog_ctr + 12'd1;
    if (m_mode == M_IDLE) begin
      e_pc_reset = 1;
      if (start) nxt_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      e_abs = 1; e_tgt = prog_ctr;
    end else begin
      if (halt_en) begin
        e_abs = 1; e_tgt = prog_ctr; nxt_mode = M_HALT;
      end else if (ret_en) begin
        if (m_stack.size() > 0) begin
          e_abs = 1; e_tgt = m_stack[$]; do_pop = 1;
        end else do_unf = 1;
      end else if (call_en) begin
        e_abs = 1; e_tgt = m_lut[lut_idx];
        if (m_stack.size() < 4) do_push = 1;
        else do_ovf = 1;
      end else if (br_en) begin
        e_abs = br_cond; e_tgt = m_lut[lut_idx];
      end
    end
    chk("pc_reset",   pc_reset,   e_pc_reset);
    chk("absjump_en", absjump_en, e_abs);
    chk("target",     target,     e_tgt);
    chk("done",       done,       m_done);
    chk("ras_ovf",    ras_ovf,    m_ovf);
    chk("ras_unf",    ras_unf,    m_unf);
  endtask

  // Advance the model across the clock edge and move the emulated PC.
  task automatic commit_half();
    logic [11:0] next_pc;
    @(posedge clk);
    next_pc = e_pc_reset ? 12'h000 : (e_abs ? e_tgt : prog_ctr + 12'd1);
    if (reset) begin
      model_clear();
    end else begin
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
      if (do_push) m_stack.push_back(push_val);
      if (do_pop) void'(m_stack.pop_back());
      if (do_ovf) m_ovf = 1;
      if (do_unf) m_unf = 1;
      m_mode = nxt_mode;
      m_done = (nxt_mode == M_HALT);
    end
    #1;
    prog_ctr = next_pc;
  endtask

  task automatic tick();
    check_half();
    commit_half();
  endtask

  initial begin
    //               pc     br c  ca re ha idx  abs tgt    ovf unf
    vecs[0]  = '{12'h005, 1, 1, 0, 0, 0, 5'd3, 1, 12'h040, 0, 0};
    vecs[1]  = '{12'h005, 1, 0, 0, 0, 0, 5'd3, 0, 12'h040, 0, 0};
    vecs[2]  = '{12'h010, 0, 0, 1, 0, 0, 5'd1, 1, 12'h100, 0, 0};
    vecs[3]  = '{12'h100, 0, 0, 0, 1, 0, 5'd0, 1, 12'h011, 0, 0};
    vecs[4]  = '{12'h200, 1, 1, 1, 0, 0, 5'd1, 1, 12'h100, 0, 0};
    vecs[5]  = '{12'h100, 1, 1, 1, 1, 0, 5'd3, 1, 12'h201, 0, 0};
    vecs[6]  = '{12'h020, 0, 0, 1, 0, 0, 5'd1, 1, 12'h100, 0, 0};
    vecs[7]  = '{12'h030, 0, 0, 1, 0, 0, 5'd3, 1, 12'h040, 0, 0};
    vecs[8]  = '{12'h040, 0, 0, 1, 0, 0, 5'd4, 1, 12'h300, 0, 0};
    vecs[9]  = '{12'h050, 0, 0, 1, 0, 0, 5'd1, 1, 12'h100, 0, 0};
    vecs[10] = '{12'h060, 0, 0, 1, 0, 0, 5'd3, 1, 12'h040, 0, 0};
    vecs[11] = '{12'h070, 0, 0, 0, 0, 0, 5'd0, 0, 12'h000, 1, 0};
    vecs[12] = '{12'h100, 0, 0, 0, 1, 0, 5'd0, 1, 12'h051, 1, 0};
    vecs[13] = '{12'h100, 0, 0, 0, 1, 0, 5'd0, 1, 12'h041, 1, 0};
    vecs[14] = '{12'h100, 0, 0, 0, 1, 0, 5'd0, 1, 12'h031, 1, 0};
    vecs[15] = '{12'h100, 0, 0, 0, 1, 0, 5'd0, 1, 12'h021, 1, 0};
    vecs[16] = '{12'h100, 0, 0, 0, 1, 0, 5'd0, 0, 12'h000, 1, 0};
    vecs[17] = '{12'h100, 0, 0, 0, 0, 0, 5'd0, 0, 12'h000, 1, 1};

    clear_in();
    prog_ctr = '0;
    reset = 1;
    model_clear();
    e_pc_reset = 1; e_abs = 0; e_tgt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    // Idle after reset, then start and count.
    repeat (3) begin
      check_half();
      chk("idle_pc_reset", pc_reset, 1);
      chk("idle_done", done, 0);
      chk("idle_flags", {ras_ovf, ras_unf}, 0);
      commit_half();
    end
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      check_half();
      chk("run_pc_reset", pc_reset, 0);
      chk("run_increment", absjump_en, 0);
      commit_half();
    end

    // LUT setup.
    lut_we = 1;
    lut_waddr = 5'd3; lut_wdata = 12'h040; tick();
    lut_waddr = 5'd1; lut_wdata = 12'h100; tick();
    lut_waddr = 5'd4; lut_wdata = 12'h300; tick();
    clear_in();

    // Branch, call/return, overflow and underflow vectors.
    for (int i = 0; i < 18; i++) begin
      clear_in();
      prog_ctr = vecs[i].pc;
      br_en = vecs[i].br; br_cond = vecs[i].cond; call_en = vecs[i].call;
      ret_en = vecs[i].ret; halt_en = vecs[i].halt; lut_idx = vecs[i].idx;
      check_half();
      chk($sformatf("vec%0d_abs", i), absjump_en, vecs[i].x_abs);
      chk($sformatf("vec%0d_tgt", i), target, vecs[i].x_tgt);
      chk($sformatf("vec%0d_ovf", i), ras_ovf, vecs[i].x_ovf);
      chk($sformatf("vec%0d_unf", i), ras_unf, vecs[i].x_unf);
      commit_half();
    end
    clear_in();

    // Halt beats a simultaneous call; PC frozen; start ignored.
    prog_ctr = 12'h020; halt_en = 1; call_en = 1; lut_idx = 5'd1;
    check_half();
    chk("halt_abs", absjump_en, 1);
    chk("halt_tgt", target, 12'h020);
    commit_half();
    clear_in();
    for (int i = 0; i < 10; i++) begin
      start = 1; call_en = 1; ret_en = $urandom_range(0, 1); lut_idx = 5'd1;
      check_half();
      chk("halt_done", done, 1);
      chk("halt_hold", target, 12'h020);
      chk("halt_no_reset", pc_reset, 0);
      commit_half();
    end
    clear_in();
    reset = 1; tick(); reset = 0;
    check_half();
    chk("post_reset_idle", pc_reset, 1);
    chk("post_reset_done", done, 0);
    chk("post_reset_ovf", ras_ovf, 0);
    commit_half();

    // Return-address wrap and LUT read-before-write.
    start = 1; tick(); start = 0;
    lut_we = 1; lut_waddr = 5'd2; lut_wdata = 12'h0AB; tick();
    clear_in();
    prog_ctr = 12'hFFF; call_en = 1; lut_idx = 5'd2;
    lut_we = 1; lut_waddr = 5'd2; lut_wdata = 12'h555;
    check_half();
    chk("lut_old_value", target, 12'h0AB);
    commit_half();
    clear_in();
    ret_en = 1;
    check_half();
    chk("ret_wrap_abs", absjump_en, 1);
    chk("ret_wrap_tgt", target, 12'h000);
    commit_half();
    clear_in();
    br_en = 1; br_cond = 1; lut_idx = 5'd2;
    check_half();
    chk("lut_new_value", target, 12'h555);
    commit_half();

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 3) == 0);
      halt_en = ($urandom_range(0, 63) == 0);
      ret_en  = ($urandom_range(0, 3) == 0);
      call_en = ($urandom_range(0, 3) == 0);
      br_en   = ($urandom_range(0, 2) == 0);
      br_cond = 1'($urandom);
      lut_idx = 5'($urandom);
      lut_we  = ($urandom_range(0, 3) == 0);
      lut_waddr = ($urandom_range(0, 1) == 0) ? lut_idx : 5'($urandom);
      lut_wdata = 12'($urandom);
      if ($urandom_range(0, 15) == 0) prog_ctr = 12'hFFF;
      tick();
    end
    reset = 0;
    clear_in();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
